// File: rtl/branch_operand_fwd_pkg.sv
// Shared types and constants for the ID-stage branch operand forwarding block.
// Forward-select codes, FSM state encoding and per-hazard stall depths.
package branch_operand_fwd_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    localparam logic [1:0] STALL_NONE     = 2'd0;
    localparam logic [1:0] STALL_LOAD_EX  = 2'd2;
    localparam logic [1:0] STALL_ALU_EX   = 2'd1;
    localparam logic [1:0] STALL_LOAD_MEM = 2'd1;

    function automatic logic [1:0] max_need(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/branch_operand_fwd_if.sv
// Pipeline-side bundle for branch_operand_fwd: ID sources, EX/MEM/WB writer
// state in, comparator operands and stall out.
interface branch_operand_fwd_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              id_branch;
    logic [REG_W-1:0]  id_rs;
    logic [REG_W-1:0]  id_rt;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic [REG_W-1:0]  ex_rd;
    logic              mem_reg_write;
    logic              mem_mem_read;
    logic [REG_W-1:0]  mem_rd;
    logic [DATA_W-1:0] mem_alu_result;
    logic              wb_reg_write;
    logic [REG_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] cmp_a;
    logic [DATA_W-1:0] cmp_b;
    logic              stall;

    modport master (
        output id_branch, id_rs, id_rt, id_rs_data, id_rt_data,
        output ex_reg_write, ex_mem_read, ex_rd,
        output mem_reg_write, mem_mem_read, mem_rd, mem_alu_result,
        output wb_reg_write, wb_rd, wb_data,
        input  cmp_a, cmp_b, stall
    );

    modport slave (
        input  id_branch, id_rs, id_rt, id_rs_data, id_rt_data,
        input  ex_reg_write, ex_mem_read, ex_rd,
        input  mem_reg_write, mem_mem_read, mem_rd, mem_alu_result,
        input  wb_reg_write, wb_rd, wb_data,
        output cmp_a, cmp_b, stall
    );
endinterface

// File: rtl/branch_operand_fwd_mux.sv
// branch_fwd_mux: one branch operand's dependency match, forward-source
// priority (MEM ALU result, then WB data, then register file) and stall need.
module branch_fwd_mux
    import branch_operand_fwd_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic [REG_W-1:0]  src,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              mem_reg_write,
    input  logic              mem_mem_read,
    input  logic [REG_W-1:0]  mem_rd,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic              wb_reg_write,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] data,
    output logic [1:0]        need
);
    logic     src_nz;
    logic     dep_ex;
    logic     dep_mem;
    logic     dep_wb;
    fwd_sel_t sel;

    // r0 is hardwired; it can never carry a hazard or a forwarded value
    assign src_nz  = (src != '0);
    assign dep_ex  = ex_reg_write  && (ex_rd  == src) && src_nz;
    assign dep_mem = mem_reg_write && (mem_rd == src) && src_nz;
    assign dep_wb  = wb_reg_write  && (wb_rd  == src) && src_nz;

    always_comb begin
        sel = FWD_RF;
        if (dep_mem && !mem_mem_read) begin
            sel = FWD_MEM;
        end else if (dep_wb) begin
            sel = FWD_WB;
        end
    end

    always_comb begin
        data = rf_data;
        case (sel)
            FWD_MEM: data = mem_alu_result;
            FWD_WB:  data = wb_data;
            default: data = rf_data;
        endcase
    end

    always_comb begin
        need = STALL_NONE;
        if (dep_ex && ex_mem_read) begin
            need = STALL_LOAD_EX;
        end else if (dep_ex) begin
            need = STALL_ALU_EX;
        end else if (dep_mem && mem_mem_read) begin
            need = STALL_LOAD_MEM;
        end
    end

endmodule

// File: rtl/branch_operand_fwd.sv
// ID-stage branch operand forwarding with counted stall FSM.
// Optional stall statistics counter enabled by BRANCH_STALL_STATS_EN.
module branch_operand_fwd
    import branch_operand_fwd_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
`ifdef BRANCH_STALL_STATS_EN
    ,
    parameter int CNT_W  = 32
`endif
) (
    input  logic                clk,
    input  logic                reset,
    branch_operand_fwd_if.slave bus
`ifdef BRANCH_STALL_STATS_EN
    ,
    output logic [CNT_W-1:0]    stall_cycles
`endif
);
    logic [DATA_W-1:0] data_rs;
    logic [DATA_W-1:0] data_rt;
    logic [1:0]        need_rs;
    logic [1:0]        need_rt;
    logic [1:0]        need;
    state_t            state;
    state_t            state_next;
    logic [1:0]        cnt;
    logic [1:0]        cnt_next;
    logic              stall_int;

    branch_fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_mux_rs (
        .src            (bus.id_rs),
        .rf_data        (bus.id_rs_data),
        .ex_reg_write   (bus.ex_reg_write),
        .ex_mem_read    (bus.ex_mem_read),
        .ex_rd          (bus.ex_rd),
        .mem_reg_write  (bus.mem_reg_write),
        .mem_mem_read   (bus.mem_mem_read),
        .mem_rd         (bus.mem_rd),
        .mem_alu_result (bus.mem_alu_result),
        .wb_reg_write   (bus.wb_reg_write),
        .wb_rd          (bus.wb_rd),
        .wb_data        (bus.wb_data),
        .data           (data_rs),
        .need           (need_rs)
    );

    branch_fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_mux_rt (
        .src            (bus.id_rt),
        .rf_data        (bus.id_rt_data),
        .ex_reg_write   (bus.ex_reg_write),
        .ex_mem_read    (bus.ex_mem_read),
        .ex_rd          (bus.ex_rd),
        .mem_reg_write  (bus.mem_reg_write),
        .mem_mem_read   (bus.mem_mem_read),
        .mem_rd         (bus.mem_rd),
        .mem_alu_result (bus.mem_alu_result),
        .wb_reg_write   (bus.wb_reg_write),
        .wb_rd          (bus.wb_rd),
        .wb_data        (bus.wb_data),
        .data           (data_rt),
        .need           (need_rt)
    );

    // Both operands share one stall window, so the longer need covers both
    assign need = max_need(need_rs, need_rt);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stall_int  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.id_branch && (need != STALL_NONE)) begin
                    stall_int = 1'b1;
                    cnt_next  = need - 2'd1;
                    if (need > 2'd1) begin
                        state_next = ST_STALL;
                    end
                end
            end
            ST_STALL: begin
                // hazard inputs are ignored here; ID is frozen for the count
                stall_int = 1'b1;
                cnt_next  = cnt - 2'd1;
                if (cnt == 2'd1) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
        if (reset) begin
            stall_int = 1'b0;
        end
    end

    assign bus.cmp_a = data_rs;
    assign bus.cmp_b = data_rt;
    assign bus.stall = stall_int;

`ifdef BRANCH_STALL_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall_int && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_ONE;
        end
    end
`endif

endmodule

// File: tb/tb_branch_operand_fwd.sv
// Self-checking bench for branch_operand_fwd: vector table, hand-written
// multi-cycle sequences and randomized traffic against a reference model.
module tb_branch_operand_fwd;

    logic clk;
    logic reset;
`ifdef BRANCH_STALL_STATS_EN
    logic [31:0] stall_cycles;
`endif

    int total;
    int bad;

    branch_operand_fwd_if #(.DATA_W(32), .REG_W(5)) bus ();

    branch_operand_fwd #(.DATA_W(32), .REG_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef BRANCH_STALL_STATS_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        br;
        int          rs;
        int          rt;
        logic [31:0] rs_d;
        logic [31:0] rt_d;
        logic        exw;
        logic        exmr;
        int          exrd;
        logic        memw;
        logic        memmr;
        int          memrd;
        logic [31:0] alu;
        logic        wbw;
        int          wbrd;
        logic [31:0] wbd;
        logic [31:0] ea;
        logic [31:0] eb;
        logic        es;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        bus.id_branch      = 1'b0;
        bus.id_rs          = '0;
        bus.id_rt          = '0;
        bus.id_rs_data     = '0;
        bus.id_rt_data     = '0;
        bus.ex_reg_write   = 1'b0;
        bus.ex_mem_read    = 1'b0;
        bus.ex_rd          = '0;
        bus.mem_reg_write  = 1'b0;
        bus.mem_mem_read   = 1'b0;
        bus.mem_rd         = '0;
        bus.mem_alu_result = '0;
        bus.wb_reg_write   = 1'b0;
        bus.wb_rd          = '0;
        bus.wb_data        = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v);
        bus.id_branch      = v.br;
        bus.id_rs          = 5'(v.rs);
        bus.id_rt          = 5'(v.rt);
        bus.id_rs_data     = v.rs_d;
        bus.id_rt_data     = v.rt_d;
        bus.ex_reg_write   = v.exw;
        bus.ex_mem_read    = v.exmr;
        bus.ex_rd          = 5'(v.exrd);
        bus.mem_reg_write  = v.memw;
        bus.mem_mem_read   = v.memmr;
        bus.mem_rd         = 5'(v.memrd);
        bus.mem_alu_result = v.alu;
        bus.wb_reg_write   = v.wbw;
        bus.wb_rd          = 5'(v.wbrd);
        bus.wb_data        = v.wbd;
    endtask

    // Reference: stall depth an operand needs from the writers now in flight
    function automatic int ref_need(input int s);
        if (s == 0) return 0;
        if (bus.ex_reg_write && int'(bus.ex_rd) == s) return bus.ex_mem_read ? 2 : 1;
        if (bus.mem_reg_write && int'(bus.mem_rd) == s && bus.mem_mem_read) return 1;
        return 0;
    endfunction

    // Reference: newest architecturally available value of a register
    function automatic logic [31:0] ref_value(input int s, input logic [31:0] rf);
        if (s != 0 && bus.mem_reg_write && int'(bus.mem_rd) == s && !bus.mem_mem_read)
            return bus.mem_alu_result;
        if (s != 0 && bus.wb_reg_write && int'(bus.wb_rd) == s)
            return bus.wb_data;
        return rf;
    endfunction

    initial begin
        int rem;
        int n;
        int stat;
        logic exp_stall;

        total = 0;
        bad   = 0;
        reset = 1'b1;
        clear_inputs();

        //          br rs rt rs_d     rt_d     exw exmr exrd memw memmr memrd alu      wbw wbrd wbd      ea       eb       es
        vecs[0]  = '{1, 3, 4, 32'h5,  32'h5,  0,  0,   0,   0,   0,    0,    32'h0,   0,  0,   32'h0,   32'h5,   32'h5,   0};
        vecs[1]  = '{1, 0, 0, 32'h7,  32'h9,  1,  0,   0,   1,   0,    0,    32'h11,  1,  0,   32'h22,  32'h7,   32'h9,   0};
        vecs[2]  = '{1, 3, 4, 32'h1,  32'h2,  0,  0,   0,   1,   0,    3,    32'h10,  0,  0,   32'h0,   32'h10,  32'h2,   0};
        vecs[3]  = '{1, 5, 1, 32'h1,  32'h2,  0,  0,   0,   1,   0,    5,    32'hAA,  1,  5,   32'hBB,  32'hAA,  32'h2,   0};
        vecs[4]  = '{1, 1, 6, 32'h1,  32'h2,  0,  0,   0,   0,   0,    0,    32'h0,   1,  6,   32'h66,  32'h1,   32'h66,  0};
        vecs[5]  = '{1, 5, 1, 32'h1,  32'h2,  0,  0,   0,   1,   1,    5,    32'hAA,  1,  5,   32'hBB,  32'h0,   32'h0,   1};
        vecs[6]  = '{0, 2, 7, 32'h3,  32'h4,  1,  1,   2,   1,   0,    7,    32'h77,  0,  0,   32'h0,   32'h3,   32'h77,  0};
        vecs[7]  = '{1, 1, 2, 32'h1,  32'h2,  1,  0,   2,   0,   0,    0,    32'h0,   0,  0,   32'h0,   32'h0,   32'h0,   1};
        vecs[8]  = '{1, 1, 2, 32'h1,  32'h2,  1,  1,   3,   0,   0,    0,    32'h0,   0,  0,   32'h0,   32'h1,   32'h2,   0};
        vecs[9]  = '{1, 3, 4, 32'h31, 32'h41, 0,  0,   0,   0,   0,    3,    32'hDD,  0,  0,   32'h0,   32'h31,  32'h41,  0};
        vecs[10] = '{1, 3, 9, 32'h31, 32'h41, 0,  0,   0,   1,   1,    3,    32'hDD,  1,  9,   32'h99,  32'h0,   32'h0,   1};

        next_cycle();
        @(negedge clk);
        chk("reset_stall", {31'b0, bus.stall}, 32'h0);
`ifdef BRANCH_STALL_STATS_EN
        chk("reset_stats", stall_cycles, 32'h0);
`endif
        next_cycle();
        reset = 1'b0;

        // Table of single-cycle decisions, each from a freshly reset FSM
        for (int i = 0; i < 11; i++) begin
            do_reset();
            apply_vec(vecs[i]);
            @(negedge clk);
            chk($sformatf("vec%0d_stall", i), {31'b0, bus.stall}, {31'b0, vecs[i].es});
            if (!vecs[i].es) begin
                chk($sformatf("vec%0d_cmp_a", i), bus.cmp_a, vecs[i].ea);
                chk($sformatf("vec%0d_cmp_b", i), bus.cmp_b, vecs[i].eb);
            end
        end

        // ALU dependency then load dependency, back to back
        do_reset();
        bus.id_branch = 1'b1; bus.id_rs = 5'd3; bus.id_rs_data = 32'h99;
        bus.ex_reg_write = 1'b1; bus.ex_rd = 5'd3;
        @(negedge clk);
        chk("alu_c1_stall", {31'b0, bus.stall}, 32'h1);
        next_cycle();
        bus.ex_reg_write = 1'b0; bus.ex_rd = '0;
        bus.mem_reg_write = 1'b1; bus.mem_rd = 5'd3; bus.mem_alu_result = 32'h10;
        @(negedge clk);
        chk("alu_c2_stall", {31'b0, bus.stall}, 32'h0);
        chk("alu_c2_cmp_a", bus.cmp_a, 32'h10);
        next_cycle();
        clear_inputs();
        bus.id_branch = 1'b1; bus.id_rt = 5'd4; bus.id_rt_data = 32'h44;
        bus.ex_reg_write = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd4;
        @(negedge clk);
        chk("ld_c1_stall", {31'b0, bus.stall}, 32'h1);
        next_cycle();
        bus.ex_reg_write = 1'b0; bus.ex_mem_read = 1'b0; bus.ex_rd = '0;
        bus.mem_reg_write = 1'b1; bus.mem_mem_read = 1'b1; bus.mem_rd = 5'd4;
        @(negedge clk);
        chk("ld_c2_stall", {31'b0, bus.stall}, 32'h1);
        next_cycle();
        bus.mem_reg_write = 1'b0; bus.mem_mem_read = 1'b0; bus.mem_rd = '0;
        bus.wb_reg_write = 1'b1; bus.wb_rd = 5'd4; bus.wb_data = 32'hBEEF;
        @(negedge clk);
        chk("ld_c3_stall", {31'b0, bus.stall}, 32'h0);
        chk("ld_c3_cmp_b", bus.cmp_b, 32'hBEEF);
`ifdef BRANCH_STALL_STATS_EN
        chk("stats_after_seq", stall_cycles, 32'd3);
        do_reset();
        @(negedge clk);
        chk("stats_after_reset", stall_cycles, 32'd0);
`endif

        // Both operands hazardous: one window of max depth, not the sum
        do_reset();
        bus.id_branch = 1'b1; bus.id_rs = 5'd2; bus.id_rt = 5'd3;
        bus.ex_reg_write = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd2;
        bus.mem_reg_write = 1'b1; bus.mem_mem_read = 1'b1; bus.mem_rd = 5'd3;
        @(negedge clk);
        chk("both_c1_stall", {31'b0, bus.stall}, 32'h1);
        next_cycle();
        @(negedge clk);
        chk("both_c2_stall", {31'b0, bus.stall}, 32'h1);
        next_cycle();
        clear_inputs();
        bus.id_branch = 1'b1; bus.id_rs = 5'd2; bus.id_rt = 5'd3;
        @(negedge clk);
        chk("both_c3_stall", {31'b0, bus.stall}, 32'h0);

        // id_branch dropping mid-stall does not cut the count short
        do_reset();
        bus.id_branch = 1'b1; bus.id_rs = 5'd4;
        bus.ex_reg_write = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd4;
        next_cycle();
        clear_inputs();
        @(negedge clk);
        chk("drop_c2_stall", {31'b0, bus.stall}, 32'h1);
        next_cycle();
        @(negedge clk);
        chk("drop_c3_stall", {31'b0, bus.stall}, 32'h0);

        // Reset on the second stall cycle leaves no residual count
        do_reset();
        bus.id_branch = 1'b1; bus.id_rt = 5'd4;
        bus.ex_reg_write = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd4;
        @(negedge clk);
        chk("rst_c1_stall", {31'b0, bus.stall}, 32'h1);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        clear_inputs();
        bus.id_branch = 1'b1; bus.id_rt = 5'd4;
        @(negedge clk);
        chk("rst_after_stall", {31'b0, bus.stall}, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("rst_after2_stall", {31'b0, bus.stall}, 32'h0);

        // Randomized traffic against the reference model
        do_reset();
        rem  = 0;
        stat = 0;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            bus.id_branch      = ($urandom_range(0, 3) != 0);
            bus.id_rs          = 5'($urandom_range(0, 3));
            bus.id_rt          = 5'($urandom_range(0, 3));
            bus.id_rs_data     = $urandom;
            bus.id_rt_data     = $urandom;
            bus.ex_reg_write   = ($urandom_range(0, 2) == 0);
            bus.ex_mem_read    = $urandom_range(0, 1) == 1;
            bus.ex_rd          = 5'($urandom_range(0, 3));
            bus.mem_reg_write  = $urandom_range(0, 1) == 1;
            bus.mem_mem_read   = $urandom_range(0, 1) == 1;
            bus.mem_rd         = 5'($urandom_range(0, 3));
            bus.mem_alu_result = $urandom;
            bus.wb_reg_write   = $urandom_range(0, 1) == 1;
            bus.wb_rd          = 5'($urandom_range(0, 3));
            bus.wb_data        = $urandom;
            @(negedge clk);
            if (reset) begin
                exp_stall = 1'b0;
                rem = 0;
            end else if (rem > 0) begin
                exp_stall = 1'b1;
                rem = rem - 1;
            end else begin
                n = 0;
                if (bus.id_branch) begin
                    n = ref_need(int'(bus.id_rs));
                    if (ref_need(int'(bus.id_rt)) > n) n = ref_need(int'(bus.id_rt));
                end
                exp_stall = (n > 0);
                rem = (n > 0) ? n - 1 : 0;
            end
            chk("rnd_stall", {31'b0, bus.stall}, {31'b0, exp_stall});
            if (!exp_stall) begin
                chk("rnd_cmp_a", bus.cmp_a, ref_value(int'(bus.id_rs), bus.id_rs_data));
                chk("rnd_cmp_b", bus.cmp_b, ref_value(int'(bus.id_rt), bus.id_rt_data));
            end
`ifdef BRANCH_STALL_STATS_EN
            chk("rnd_stats", stall_cycles, 32'(stat));
            if (reset) stat = 0;
            else if (exp_stall) stat = stat + 1;
`endif
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/branch_operand_fwd.md
Name: branch_operand_fwd

Overview:
- ID-stage operand supplier for the branch comparator, sitting directly upstream of it.
- Selects the freshest value of branch rs/rt from the register file, the EX/MEM ALU result or the WB write data, and drives the comparator's a/b inputs.
- Detects data hazards that forwarding cannot cover and holds PC and IF/ID with a counted stall FSM, inserting bubbles into ID/EX, until the operands are valid.

Parameters:
- DATA_W, 32, operand/data width.
- REG_W, 5, register specifier width.
- CNT_W, 32, width of stall statistics counter (optional feature only).

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- id_branch  in  1  instruction in ID is beq/bne.
- id_rs, id_rt  in  REG_W  source specifiers in ID.
- id_rs_data, id_rt_data  in  DATA_W  register file read data.
- ex_reg_write, ex_mem_read  in  1  ID/EX control: writes a register / is a load.
- ex_rd  in  REG_W  ID/EX destination register.
- mem_reg_write, mem_mem_read  in  1  EX/MEM control.
- mem_rd  in  REG_W  EX/MEM destination register.
- mem_alu_result  in  DATA_W  EX/MEM ALU result.
- wb_reg_write  in  1  MEM/WB register write enable.
- wb_rd  in  REG_W  MEM/WB destination register.
- wb_data  in  DATA_W  final WB write data.
- cmp_a, cmp_b  out  DATA_W  to comparator a/b (combinational).
- stall  out  1  freeze PC and IF/ID; zero ID/EX control.
- stall_cycles  out  CNT_W  present only with the optional feature.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - reset is synchronous and active-high.
  - During and after reset: state=IDLE, cnt=0, stall=0, stall_cycles=0.
  - cmp_a/cmp_b are combinational and have no reset value.
- Dependency match, per operand s in {rs, rt}:
  - dep_ex = ex_reg_write & ex_rd==s & s!=0.
  - dep_mem and dep_wb are defined the same way from the mem_* and wb_* signals.
  - Register 0 never matches, is never forwarded and never stalls.
- Forward select, per operand, by priority:
  - dep_mem & !mem_mem_read → mem_alu_result.
  - else dep_wb → wb_data.
  - else register file data.
  - The EX stage is never a forward source.
- Stall need N, evaluated only in IDLE with id_branch=1; take the maximum over both operands:
  - dep_ex & ex_mem_read → 2.
  - dep_ex & !ex_mem_read → 1.
  - dep_mem & mem_mem_read → 1.
  - otherwise → 0.
- FSM, states IDLE and STALL, with a 2-bit counter cnt:
  - IDLE, N=0: stall=0; cmp outputs valid this cycle.
  - IDLE, N≥1: stall=1 this cycle (combinational); cnt<=N-1; go to STALL if N-1>0, else stay in IDLE.
  - STALL: stall=1; cnt<=cnt-1; when cnt==1, go to IDLE. Hazard inputs are ignored while in STALL.
- Worst-case latency: lw r4 immediately before beq r4 → 2 stall cycles, then cmp_b=wb_data in the third cycle.
- Boundary conditions:
  - id_branch=0: stall=0; cmp outputs still driven per the forward rules; the FSM does not leave IDLE.
  - Both operands hazardous: a single stall of max(N_rs, N_rt) cycles, not the sum.
  - dep_mem and dep_wb on the same register: MEM wins (newer value).
  - id_branch dropping while in STALL: the count still completes (ID is frozen, so this is illegal upstream).
  - reset while in STALL: stall deasserts in the cycle after the reset edge; no residual count survives.
  - In IDLE with N≥1, cmp outputs are don't-care; the comparator result is discarded by the stall.

Optional Feature:
- Macro: BRANCH_STALL_STATS_EN.
- When defined:
  - port stall_cycles exists;
  - it increments by 1 on every clk edge where stall=1 and reset=0;
  - it saturates at all-ones and clears on reset.
- When undefined: the port and counter are absent, and the remaining behaviour is identical.

Decomposition:
- Shared package holds:
  - forward-select constants FWD_RF=2'd0, FWD_MEM=2'd1, FWD_WB=2'd2;
  - state encoding ST_IDLE=1'b0, ST_STALL=1'b1;
  - localparams for the stall depths: STALL_LOAD_EX=2, STALL_ALU_EX=1, STALL_LOAD_MEM=1.
- One sub-module, branch_fwd_mux: one operand's dependency match, forward-select priority and stall-need calculation. It is instantiated twice (rs, rt); the top takes the max of the two needs and owns the FSM.

Test Plan:
- No hazard: beq r3,r4; rs_data=5, rt_data=5; no writers → cmp_a=5, cmp_b=5, stall=0.
- ALU dependency: add r3 in EX, beq r3,r0 → stall=1 for 1 cycle. Next cycle mem_rd=3, mem_alu_result=0x10 → cmp_a=0x10, stall=0.
- Load dependency: lw r4 in EX, beq r0,r4 → stall=1 for exactly 2 cycles. Third cycle wb_rd=4, wb_data=0xBEEF → cmp_b=0xBEEF.
- Register 0: ex_rd=0 with ex_reg_write=1, beq r0,r0 → no stall; cmp_a=cmp_b=id data.
- Reset during stall: lw hazard, assert reset on the second stall cycle → stall=0 and FSM in IDLE on the following cycle.
- Feature on: run the ALU-dependency and load-dependency scenarios back to back → stall_cycles=3; after reset → 0.
